// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester round-robin writeback arbiter for a shared register-file write port
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [ADDR_W-1:0] chk_addrA,
    input  logic [ADDR_W-1:0] chk_addrB,
    output logic              chk_busyA,
    output logic              chk_busyB,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [1:0]        slot_v;
    logic [ADDR_W-1:0] slot_addr [2];
    logic [DATA_W-1:0] slot_data [2];
    logic              rr_ptr;
    logic [1:0]        grant;
    logic [1:0]        accept;
    logic              both_full;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];

    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    assign both_full = &slot_v;

    // Grant a lone full slot directly; when both are full the round-robin pointer decides.
    always_comb begin
        grant = 2'b00;
        if (both_full) begin
            grant = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            grant = slot_v;
        end
    end

    // A slot that is draining this cycle can take a new request with no bubble.
    assign req0_ready = !slot_v[0] || grant[0];
    assign req1_ready = !slot_v[1] || grant[1];
    assign accept[0]  = req0_valid && req0_ready;
    assign accept[1]  = req1_valid && req1_ready;

    // Drive the register-file port from whichever slot holds the grant.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (grant[0]) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = slot_addr[0];
            rf_wr_data = slot_data[0];
        end else if (grant[1]) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = slot_addr[1];
            rf_wr_data = slot_data[1];
        end
    end

    // Hazard flags look only at held slot state; x0 is never busy.
    always_comb begin
        chk_busyA = (chk_addrA != '0) &&
                    ((slot_v[0] && (slot_addr[0] == chk_addrA)) ||
                     (slot_v[1] && (slot_addr[1] == chk_addrA)));
        chk_busyB = (chk_addrB != '0) &&
                    ((slot_v[1] && (slot_addr[1] == chk_addrB)) ||
                     (slot_v[0] && (slot_addr[0] == chk_addrB)));
    end

    // Slot load/drain: writes to x0 are acknowledged but never held.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot_v <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                slot_addr[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i] && (req_addr[i] != '0)) begin
                    slot_v[i]    <= 1'b1;
                    slot_addr[i] <= req_addr[i];
                    slot_data[i] <= req_data[i];
                end else if (grant[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer hands priority to the other requester after a contended cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_ptr <= 1'b0;
        end else if (both_full) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Saturating count of cycles with both slots full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            conflict_cnt <= '0;
        end else if (both_full && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (wr_en/wr_addr/wr_data) between two writeback requesters, e.g. ALU writeback and load writeback. Each requester has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter drains the slots into the register file, one write per cycle. The block also provides pending-write hazard flags for the two read ports (A/B), plus a saturating conflict counter for performance monitoring.

Parameters:
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width
CNT_W, 16, width of conflict counter

Ports:
clk  input  1  clock, rising-edge
nrst  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a write
req0_ready  output  1  requester 0 slot can accept
req0_addr  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req1_valid  input  1  requester 1 has a write
req1_ready  output  1  requester 1 slot can accept
req1_addr  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  ADDR_W  register-file write address
rf_wr_data  output  DATA_W  register-file write data
chk_addrA  input  ADDR_W  read port A address under check
chk_addrB  input  ADDR_W  read port B address under check
chk_busyA  output  1  pending write to chk_addrA held in a slot
chk_busyB  output  1  pending write to chk_addrB held in a slot
conflict_cnt  output  CNT_W  cycles in which both slots were full

Behaviour:
- Reset (nrst low, async): both slots empty, rr_ptr=0 (requester 0 favoured), conflict_cnt=0. This forces rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, chk_busyA/B=0 and req0_ready=req1_ready=1.
- Slot i state: slot_v, slot_addr, slot_data. Accept on the rising edge when reqi_valid && reqi_ready; addr/data are captured.
- Ready rule: reqi_ready = !slot_v[i] || grant[i]. This allows back-to-back accept in the same cycle the slot drains, with no bubble.
- x0 drop: an accepted request with addr==0 is acknowledged but does not load the slot. It never produces rf_wr_en.
- Grant (combinational from slot registers):
  - Only one slot full: grant that slot.
  - Both full: grant the slot selected by rr_ptr.
  - Neither full: no grant.
- Outputs: rf_wr_en = grant to any slot; rf_wr_addr/data come from the granted slot, else 0. The register file commits at the next edge.
- Latency: a request accepted at edge N drives rf_wr_en during cycle N..N+1 if uncontended, and is written at edge N+1. A contended loser is delayed by one extra cycle.
- On the edge after a grant: the granted slot_v clears unless it is reloaded by a simultaneous accept. rr_ptr moves to the other requester only when both slots were full.
- Same-address race: if both slots hold the same addr, writes commit in grant order, so the later-granted data survives. No ordering is guaranteed across requesters beyond round-robin order.
- Hazard flags: chk_busyX = (chk_addrX != 0) && ((slot_v[0] && slot_addr[0]==chk_addrX) || (slot_v[1] && slot_addr[1]==chk_addrX)). Purely from registered slot state; there is no bypass of same-cycle inputs.
- conflict_cnt: increments on each edge where both slot_v are set. It saturates at all-ones and does not wrap.
- Reset mid-operation discards held writes immediately. rf_wr_en drops asynchronously with nrst.

Test Plan:
- Reset: nrst=0 with both req valid -> rf_wr_en=0, both ready=1, conflict_cnt=0, busy flags 0. After release, slots stay empty until the first accept.
- Single write: req0 addr=10 data=11425652 accepted at edge N -> cycle N..N+1 shows rf_wr_en=1, addr=10, data=11425652; register 10 reads 11425652 after edge N+1.
- Contention: both valid at the same edge (req0 a=11 d=11425653, req1 a=12 d=7) -> req0 is written first, req1 one cycle later. conflict_cnt=1, rr_ptr=1; repeating the pattern gives req1 first.
- Streaming: req0 valid for 4 consecutive cycles with no req1 -> ready stays 1, with 4 consecutive rf_wr_en pulses and no bubbles.
- x0 and hazard: req1 addr=0 -> acknowledged, no rf_wr_en. With slot0 holding addr=5 and chk_addrA=5, chk_addrB=0 -> busyA=1, busyB=0; busyA clears after the drain edge.
- Async reset mid-flight: both slots full, nrst pulsed low between edges -> rf_wr_en=0 immediately, held writes lost, no write reaches the register file.
